fetch_unit: RTL and testbench

Instruction fetch/decode front-end that consumes the one-hot phase strobes (waits, fetcha, fetchb, execa, execb) of the five-state stage sequencer. It holds the program counter, reads two bytes per instruction from byte-wide instruction memory, assembles the 16-bit instruction register, applies jumps from the execute unit, and returns the halt request to the sequencer. The sequencer changes state on negedge clk; this block samples the strobes on posedge clk, mid-phase, when they are stable.

---
 rtl/fetch_unit_if.sv | 53 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the signals between the fetch/decode front-end, the stage
//   sequencer, the byte-wide instruction memory and the execute unit.
//
//   master : the fetch unit itself
//            in : phase strobes, memory read data, jump request
//            out: memory address/read enable, pc, ir, ir_valid, halt,
//                 strobe_err
//   slave  : the surrounding system (sequencer + memory + execute unit),
//            with the directions reversed
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    // phase strobes from the sequencer
    logic              fetcha;
    logic              fetchb;
    logic              execa;
    logic              execb;

    // instruction memory
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    // execute unit jump request
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    // architectural state / status
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic              ir_valid;
    logic              halt;
    logic              strobe_err;

    modport master (
        input  fetcha, fetchb, execa, execb,
        input  mem_rdata,
        input  jump_en, jump_addr,
        output mem_addr, mem_re,
        output pc, ir, ir_valid, halt, strobe_err
    );

    modport slave (
        output fetcha, fetchb, execa, execb,
        output mem_rdata,
        output jump_en, jump_addr,
        input  mem_addr, mem_re,
        input  pc, ir, ir_valid, halt, strobe_err
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch/decode front-end driven by the one-hot phase strobes of
//   the five-state stage sequencer. The sequencer moves on negedge clk, so the
//   strobes are stable at posedge and are sampled there.
//
//   fetcha : load ir[15:8] from memory, advance pc, clear ir_valid and halt
//   fetchb : load ir[7:0] from memory, advance pc, set ir_valid
//   execa  : raise halt when the opcode ir[15:12] equals HALT_OP
//   execb  : load pc from jump_addr when jump_en is set
//   none   : everything holds (this covers the waits phase)
//
//   Ports
//     clk  : system clock, all state on posedge
//     rst  : asynchronous, active-high reset
//     bus  : fetch_unit_if.master (strobes, memory port, jump, status)
//
//   There is deliberately no phase FSM here: the phase is taken only from the
//   strobes, so this block cannot drift out of step with the sequencer.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    bus
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       ir_q;
    logic [15:0]       ir_d;
    logic              ir_valid_q;
    logic              ir_valid_d;
    logic              halt_q;
    logic              halt_d;
    logic              strobe_err_q;
    logic              strobe_err_d;

    logic              multi_hot;
    logic [ADDR_W-1:0] pc_inc;

    // Any pair of active strobes is illegal; waits is not a strobe input here.
    assign multi_hot = (bus.fetcha & bus.fetchb) |
                       (bus.fetcha & bus.execa)  |
                       (bus.fetcha & bus.execb)  |
                       (bus.fetchb & bus.execa)  |
                       (bus.fetchb & bus.execb)  |
                       (bus.execa  & bus.execb);

    // Natural modulo-2^ADDR_W wrap, no flag.
    assign pc_inc = pc_q + PC_ONE;

    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        halt_d       = halt_q;
        strobe_err_d = strobe_err_q | multi_hot;

        // Priority chain: on an illegal multi-hot pattern only the
        // highest-priority phase acts.
        if (bus.fetcha) begin
            ir_d[15:8] = bus.mem_rdata;
            pc_d       = pc_inc;
            ir_valid_d = 1'b0;
            halt_d     = 1'b0;
        end else if (bus.fetchb) begin
            ir_d[7:0]  = bus.mem_rdata;
            pc_d       = pc_inc;
            ir_valid_d = 1'b1;
        end else if (bus.execa) begin
            halt_d     = (ir_q[15:12] == HALT_OP);
        end else if (bus.execb) begin
            // Jump and halt may coexist: halt is left untouched here.
            if (bus.jump_en) begin
                pc_d = bus.jump_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ir_q         <= 16'h0000;
            ir_valid_q   <= 1'b0;
            halt_q       <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            halt_q       <= halt_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    assign bus.mem_addr   = pc_q;
    assign bus.mem_re     = bus.fetcha | bus.fetchb;
    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.halt       = halt_q;
    assign bus.strobe_err = strobe_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Two fetch units share clock, reset and strobes: dut0 starts at pc 0x00,
//   dut1 at pc 0xFE. Each has its own byte memory. A behavioural model of the
//   fetch rules runs alongside both.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(8)) bus0 ();
    fetch_unit_if #(.ADDR_W(8)) bus1 ();

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE), .HALT_OP(4'hF)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic       fa, fb, ea, eb, je;
    logic [7:0] ja;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    assign bus0.fetcha    = fa;
    assign bus0.fetchb    = fb;
    assign bus0.execa     = ea;
    assign bus0.execb     = eb;
    assign bus0.jump_en   = je;
    assign bus0.jump_addr = ja;
    assign bus0.mem_rdata = mem0[bus0.mem_addr];
    assign bus1.fetcha    = fa;
    assign bus1.fetchb    = fb;
    assign bus1.execa     = ea;
    assign bus1.execb     = eb;
    assign bus1.jump_en   = je;
    assign bus1.jump_addr = ja;
    assign bus1.mem_rdata = mem1[bus1.mem_addr];

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state, index 0 -> dut0, 1 -> dut1
    logic [7:0]  m_pc   [2];
    logic [15:0] m_ir   [2];
    logic        m_iv   [2];
    logic        m_halt [2];
    logic        m_err  [2];

    function automatic logic [7:0] rd(input int k, input logic [7:0] a);
        return (k == 0) ? mem0[a] : mem1[a];
    endfunction

    task automatic model_reset();
        m_pc[0] = 8'h00;
        m_pc[1] = 8'hFE;
        for (int k = 0; k < 2; k++) begin
            m_ir[k]   = 16'h0000;
            m_iv[k]   = 1'b0;
            m_halt[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        {fa, fb, ea, eb, je} = '0;
        ja  = 8'h00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic a, input logic b, input logic c,
                         input logic d, input logic j, input logic [7:0] t);
        @(negedge clk);
        fa = a; fb = b; ea = c; eb = d; je = j; ja = t;
        #1;
    endtask

    // Advance one posedge; the model follows the fetch rules with the
    // strobes and memory contents seen just before the edge.
    task automatic tick();
        logic [7:0]  npc  [2];
        logic [15:0] nir  [2];
        logic        niv  [2];
        logic        nh   [2];
        logic        ne   [2];
        int          nact;
        nact = int'(fa) + int'(fb) + int'(ea) + int'(eb);
        for (int k = 0; k < 2; k++) begin
            npc[k] = m_pc[k]; nir[k] = m_ir[k]; niv[k] = m_iv[k];
            nh[k]  = m_halt[k];
            ne[k]  = m_err[k] | (nact > 1);
            if (fa) begin
                nir[k] = {rd(k, m_pc[k]), m_ir[k][7:0]};
                npc[k] = 8'((int'(m_pc[k]) + 1) % 256);
                niv[k] = 1'b0;
                nh[k]  = 1'b0;
            end else if (fb) begin
                nir[k] = {m_ir[k][15:8], rd(k, m_pc[k])};
                npc[k] = 8'((int'(m_pc[k]) + 1) % 256);
                niv[k] = 1'b1;
            end else if (ea) begin
                nh[k] = (m_ir[k][15:12] == 4'hF);
            end else if (eb && je) begin
                npc[k] = ja;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = npc[k]; m_ir[k] = nir[k]; m_iv[k] = niv[k];
            m_halt[k] = nh[k]; m_err[k] = ne[k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {fa, fb, ea, eb, je} = '0;
        ja = 8'h00;
        model_reset();
        #3;
        n_chk++; if (bus0.pc !== 8'h00) $display("FAIL reset_pc0: got %h exp 00", bus0.pc); else n_pass++;
        n_chk++; if (bus1.pc !== 8'hFE) $display("FAIL reset_pc1: got %h exp fe", bus1.pc); else n_pass++;
        n_chk++; if (bus0.ir !== 16'h0000) $display("FAIL reset_ir: got %h exp 0000", bus0.ir); else n_pass++;
        n_chk++; if ({bus0.ir_valid, bus0.halt, bus0.strobe_err} !== 3'b000)
            $display("FAIL reset_flags: got %b exp 000", {bus0.ir_valid, bus0.halt, bus0.strobe_err}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        drive(1, 0, 0, 0, 0, 8'h00);
        n_chk++; if ({bus0.mem_re, bus0.mem_addr} !== {1'b1, 8'h00})
            $display("FAIL basic_mem: got re=%b addr=%h exp re=1 addr=00", bus0.mem_re, bus0.mem_addr); else n_pass++;
        tick();
        n_chk++; if ({bus0.ir[15:8], bus0.pc, bus0.ir_valid} !== {8'h12, 8'h01, 1'b0})
            $display("FAIL basic_fetcha: got ir_hi=%h pc=%h v=%b exp 12 01 0", bus0.ir[15:8], bus0.pc, bus0.ir_valid); else n_pass++;
        drive(0, 1, 0, 0, 0, 8'h00);
        tick();
        n_chk++; if ({bus0.ir, bus0.pc, bus0.ir_valid} !== {16'h1234, 8'h02, 1'b1})
            $display("FAIL basic_fetchb: got ir=%h pc=%h v=%b exp 1234 02 1", bus0.ir, bus0.pc, bus0.ir_valid); else n_pass++;
        drive(0, 0, 1, 0, 0, 8'h00);
        tick();
        n_chk++; if (bus0.halt !== 1'b0) $display("FAIL basic_halt: got %b exp 0", bus0.halt); else n_pass++;
        drive(0, 0, 0, 1, 0, 8'h00);
        n_chk++; if (bus0.mem_re !== 1'b0) $display("FAIL basic_mem_re_off: got %b exp 0", bus0.mem_re); else n_pass++;
        tick();
        n_chk++; if (bus0.pc !== 8'h02) $display("FAIL basic_execb_pc: got %h exp 02", bus0.pc); else n_pass++;
    endtask

    task automatic test_halt();
        drive(1, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 8'h00); tick();
        n_chk++; if (bus0.halt !== 1'b1) $display("FAIL halt_execa: got %b exp 1", bus0.halt); else n_pass++;
        drive(0, 0, 0, 1, 0, 8'h00); tick();
        n_chk++; if (bus0.halt !== 1'b1) $display("FAIL halt_execb: got %b exp 1", bus0.halt); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 8'h00); tick();
        end
        n_chk++; if ({bus0.halt, bus0.pc} !== {1'b1, 8'h04})
            $display("FAIL halt_waits: got halt=%b pc=%h exp 1 04", bus0.halt, bus0.pc); else n_pass++;
        drive(1, 0, 0, 0, 0, 8'h00);
        n_chk++; if (bus0.mem_addr !== 8'h04) $display("FAIL halt_restart_addr: got %h exp 04", bus0.mem_addr); else n_pass++;
        tick();
        n_chk++; if (bus0.halt !== 1'b0) $display("FAIL halt_clear: got %b exp 0", bus0.halt); else n_pass++;
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 1, 0, 8'h00); tick();
    endtask

    task automatic test_jump();
        drive(1, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 1, 1, 8'h40); tick();
        n_chk++; if (bus0.pc !== 8'h40) $display("FAIL jump_pc: got %h exp 40", bus0.pc); else n_pass++;
        drive(1, 0, 0, 0, 1, 8'h77);
        n_chk++; if (bus0.mem_addr !== 8'h40) $display("FAIL jump_mem_addr: got %h exp 40", bus0.mem_addr); else n_pass++;
        tick();
        n_chk++; if (bus0.pc !== 8'h41) $display("FAIL jump_ignored_fetcha: got %h exp 41", bus0.pc); else n_pass++;
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 1, 0, 8'h55); tick();
        n_chk++; if (bus0.pc !== 8'h42) $display("FAIL jump_none: got %h exp 42", bus0.pc); else n_pass++;
        // halt and jump in the same instruction
        drive(1, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 1, 1, 8'h10); tick();
        n_chk++; if ({bus0.pc, bus0.halt} !== {8'h10, 1'b1})
            $display("FAIL jump_with_halt: got pc=%h halt=%b exp 10 1", bus0.pc, bus0.halt); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 0, 0, 0, 8'h00);
        n_chk++; if (bus1.mem_addr !== 8'hFE) $display("FAIL wrap_addr: got %h exp fe", bus1.mem_addr); else n_pass++;
        tick();
        n_chk++; if ({bus1.ir[15:8], bus1.pc} !== {8'hA5, 8'hFF})
            $display("FAIL wrap_fetcha: got ir_hi=%h pc=%h exp a5 ff", bus1.ir[15:8], bus1.pc); else n_pass++;
        drive(0, 1, 0, 0, 0, 8'h00); tick();
        n_chk++; if ({bus1.ir, bus1.pc} !== {16'hA55A, 8'h00})
            $display("FAIL wrap_fetchb: got ir=%h pc=%h exp a55a 00", bus1.ir, bus1.pc); else n_pass++;
    endtask

    task automatic test_multihot();
        do_reset();
        drive(1, 0, 0, 1, 1, 8'h99); tick();
        n_chk++; if ({bus0.ir[15:8], bus0.pc, bus0.strobe_err} !== {8'h12, 8'h01, 1'b1})
            $display("FAIL multihot: got ir_hi=%h pc=%h err=%b exp 12 01 1",
                     bus0.ir[15:8], bus0.pc, bus0.strobe_err); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 8'h00); tick();
        end
        n_chk++; if ({bus0.strobe_err, bus0.pc} !== {1'b1, 8'h01})
            $display("FAIL multihot_sticky: got err=%b pc=%h exp 1 01", bus0.strobe_err, bus0.pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 1, 8'h04); tick();
        drive(1, 0, 0, 0, 0, 8'h00); tick();
        n_chk++; if ({bus0.pc, bus0.ir[15:8]} !== {8'h05, 8'hF3})
            $display("FAIL rstmid_pre: got pc=%h ir_hi=%h exp 05 f3", bus0.pc, bus0.ir[15:8]); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if ({bus0.pc, bus0.ir, bus0.ir_valid, bus0.halt, bus0.strobe_err} !== {8'h00, 16'h0000, 3'b000})
            $display("FAIL rstmid_async: got pc=%h ir=%h v=%b h=%b e=%b exp 00 0000 0 0 0",
                     bus0.pc, bus0.ir, bus0.ir_valid, bus0.halt, bus0.strobe_err); else n_pass++;
        @(negedge clk);
        {fa, fb, ea, eb, je} = '0;
        #1;
        rst = 1'b0;
        model_reset();
        drive(1, 0, 0, 0, 0, 8'h00);
        n_chk++; if (bus0.mem_addr !== 8'h00) $display("FAIL rstmid_restart: got %h exp 00", bus0.mem_addr); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] s;
        int         bad;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        do_reset();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: s = 4'b1000;
                    1: s = 4'b0100;
                    2: s = 4'b0010;
                    3: s = 4'b0001;
                    default: s = 4'b0000;
                endcase
            end else begin
                s = 4'($urandom);
            end
            drive(s[3], s[2], s[1], s[0], 1'($urandom), 8'($urandom));
            n_chk++;
            if ({bus0.mem_addr, bus0.mem_re, bus1.mem_addr, bus1.mem_re} !==
                {m_pc[0], fa | fb, m_pc[1], fa | fb}) begin
                if (bad < 10) $display("FAIL rand_mem c=%0d: got %h/%b %h/%b exp %h %h", c,
                                       bus0.mem_addr, bus0.mem_re, bus1.mem_addr, bus1.mem_re, m_pc[0], m_pc[1]);
                bad++;
            end else n_pass++;
            tick();
            n_chk++;
            if ({bus0.pc, bus0.ir, bus0.ir_valid, bus0.halt, bus0.strobe_err} !==
                {m_pc[0], m_ir[0], m_iv[0], m_halt[0], m_err[0]}) begin
                if (bad < 10) $display("FAIL rand_dut0 c=%0d: got pc=%h ir=%h v%b h%b e%b exp pc=%h ir=%h v%b h%b e%b", c,
                                       bus0.pc, bus0.ir, bus0.ir_valid, bus0.halt, bus0.strobe_err,
                                       m_pc[0], m_ir[0], m_iv[0], m_halt[0], m_err[0]);
                bad++;
            end else n_pass++;
            n_chk++;
            if ({bus1.pc, bus1.ir, bus1.ir_valid, bus1.halt, bus1.strobe_err} !==
                {m_pc[1], m_ir[1], m_iv[1], m_halt[1], m_err[1]}) begin
                if (bad < 10) $display("FAIL rand_dut1 c=%0d: got pc=%h ir=%h v%b h%b e%b exp pc=%h ir=%h v%b h%b e%b", c,
                                       bus1.pc, bus1.ir, bus1.ir_valid, bus1.halt, bus1.strobe_err,
                                       m_pc[1], m_ir[1], m_iv[1], m_halt[1], m_err[1]);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        mem0[0]    = 8'h12;
        mem0[1]    = 8'h34;
        mem0[2]    = 8'hF0;
        mem0[3]    = 8'h00;
        mem0[4]    = 8'h2A;
        mem0[5]    = 8'h00;
        mem0[6]    = 8'h30;
        mem0[7]    = 8'h00;
        mem0[8'h40] = 8'h11;
        mem0[8'h41] = 8'h22;
        mem0[8'h42] = 8'hF1;
        mem0[8'h43] = 8'h00;
        mem1[8'hFE] = 8'hA5;
        mem1[8'hFF] = 8'h5A;

        test_reset();
        test_basic();
        test_halt();
        test_jump();
        test_wrap();
        test_multihot();
        mem0[4] = 8'hF3;
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
